// File: rtl/fac8_sel_ctrl_if.sv
// Block bus shared by the block source, the twiddle-select controller and the multiplier.
// The controller connects through the slave modport.
interface fac8_sel_ctrl_if #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
);
    logic                    frame_start;
    logic                    din_valid;
    logic signed [WIDTH-1:0] din_R     [DEPTH];
    logic signed [WIDTH-1:0] din_Q     [DEPTH];
    logic [2:0]              select;
    logic signed [WIDTH-1:0] mul_din_R [DEPTH];
    logic signed [WIDTH-1:0] mul_din_Q [DEPTH];
    logic                    mul_valid;
    logic                    dout_valid;
    logic                    dout_last;
    logic                    frame_err;

    modport master (
        output frame_start, din_valid, din_R, din_Q,
        input  select, mul_din_R, mul_din_Q, mul_valid, dout_valid, dout_last, frame_err
    );

    modport slave (
        input  frame_start, din_valid, din_R, din_Q,
        output select, mul_din_R, mul_din_Q, mul_valid, dout_valid, dout_last, frame_err
    );
endinterface

// File: rtl/fac8_sel_ctrl.sv
// Twiddle-set select controller for a radix-8 FFT stage: tags each incoming block with its
// position in the frame and tracks blocks through the downstream multiplier latency.
module fac8_sel_ctrl #(
    parameter int WIDTH   = 11,
    parameter int DEPTH   = 16,
    parameter int BLKS    = 8,
    parameter int MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    fac8_sel_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [2:0] LAST_IDX = 3'(BLKS - 1);

    state_t             state;
    state_t             state_next;
    logic [2:0]         blk_cnt;
    logic [2:0]         cap_idx;
    logic               cap_last;
    logic               capture;
    logic               err_next;
    logic               mul_last;
    logic               pipe_busy;
    logic [MUL_LAT-1:0] valid_pipe;
    logic [MUL_LAT-1:0] last_pipe;

    // A frame start always restarts numbering, whatever the current count is.
    assign cap_idx   = bus.frame_start ? 3'd0 : blk_cnt;
    assign cap_last  = (cap_idx == LAST_IDX);
    assign pipe_busy = bus.mul_valid | (|valid_pipe);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            IDLE, DRAIN: begin
                if (bus.din_valid && bus.frame_start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end else if (bus.din_valid) begin
                    err_next = 1'b1;
                end else if (state == DRAIN && !pipe_busy) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (bus.din_valid) begin
                    capture  = 1'b1;
                    err_next = bus.frame_start && (blk_cnt != 3'd0);
                    if (cap_last) state_next = DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the lane registers are cleared on reset because they are visible outputs, not a storage array.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt       <= 3'd0;
            bus.select    <= 3'd0;
            bus.mul_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            mul_last      <= 1'b0;
            valid_pipe    <= '0;
            last_pipe     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bus.mul_din_R[i] <= '0;
                bus.mul_din_Q[i] <= '0;
            end
        end else begin
            bus.mul_valid <= capture;
            bus.frame_err <= err_next;
            mul_last      <= capture && cap_last;
            valid_pipe[0] <= bus.mul_valid;
            last_pipe[0]  <= mul_last;
            for (int k = 1; k < MUL_LAT; k++) begin
                valid_pipe[k] <= valid_pipe[k-1];
                last_pipe[k]  <= last_pipe[k-1];
            end
            if (capture) begin
                bus.select    <= cap_idx;
                blk_cnt       <= cap_last ? 3'd0 : cap_idx + 3'd1;
                bus.mul_din_R <= bus.din_R;
                bus.mul_din_Q <= bus.din_Q;
            end
        end
    end

    assign bus.dout_valid = valid_pipe[MUL_LAT-1];
    assign bus.dout_last  = last_pipe[MUL_LAT-1];
endmodule

// File: tb/tb_fac8_sel_ctrl.sv
// Directed bench for fac8_sel_ctrl: one DUT with MUL_LAT=1 for most scenarios and one with
// MUL_LAT=3 for back-to-back frames.
module tb_fac8_sel_ctrl;
    localparam int WIDTH = 11;
    localparam int DEPTH = 16;
    localparam int BLKS  = 8;

    typedef struct {
        bit rst; bit fs; bit v; int tag;
        bit mv;  int sel; bit dv; bit dl; bit fe;
    } row_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic signed [WIDTH-1:0] exp_r  [DEPTH];
    logic signed [WIDTH-1:0] exp_q  [DEPTH];
    logic signed [WIDTH-1:0] exp3_r [DEPTH];
    logic signed [WIDTH-1:0] exp3_q [DEPTH];

    fac8_sel_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();
    fac8_sel_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if3 ();

    fac8_sel_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BLKS(BLKS), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );
    fac8_sel_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BLKS(BLKS), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Block with tag t carries lane i = 16*t + i on R and its negation on Q.
    task automatic drive1(input bit fs, input bit v, input int tag);
        if1.frame_start = fs;
        if1.din_valid   = v;
        for (int i = 0; i < DEPTH; i++) begin
            if1.din_R[i] = WIDTH'(tag * 16 + i);
            if1.din_Q[i] = WIDTH'(-(tag * 16 + i));
        end
    endtask

    task automatic drive3(input bit fs, input bit v, input int tag);
        if3.frame_start = fs;
        if3.din_valid   = v;
        for (int i = 0; i < DEPTH; i++) begin
            if3.din_R[i] = WIDTH'(tag * 16 + i);
            if3.din_Q[i] = WIDTH'(-(tag * 16 + i));
        end
    endtask

    task automatic set_exp1(input bit zero, input int tag);
        for (int i = 0; i < DEPTH; i++) begin
            exp_r[i] = zero ? '0 : WIDTH'(tag * 16 + i);
            exp_q[i] = zero ? '0 : WIDTH'(-(tag * 16 + i));
        end
    endtask

    task automatic set_exp3(input bit zero, input int tag);
        for (int i = 0; i < DEPTH; i++) begin
            exp3_r[i] = zero ? '0 : WIDTH'(tag * 16 + i);
            exp3_q[i] = zero ? '0 : WIDTH'(-(tag * 16 + i));
        end
    endtask

    function automatic int lane_diff1();
        for (int i = 0; i < DEPTH; i++)
            if (if1.mul_din_R[i] !== exp_r[i] || if1.mul_din_Q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int lane_diff3();
        for (int i = 0; i < DEPTH; i++)
            if (if3.mul_din_R[i] !== exp3_r[i] || if3.mul_din_Q[i] !== exp3_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [6:0] status1();
        return {if1.mul_valid, if1.select, if1.dout_valid, if1.dout_last, if1.frame_err};
    endfunction

    function automatic logic [6:0] status3();
        return {if3.mul_valid, if3.select, if3.dout_valid, if3.dout_last, if3.frame_err};
    endfunction

    task automatic test_reset();
        int ln;
        rst = 1'b1;
        drive1(1'b1, 1'b1, 3);
        drive3(1'b1, 1'b1, 3);
        set_exp1(1'b1, 0);
        set_exp3(1'b1, 0);
        tick();
        tick();
        checks++;
        if (status1() !== 7'b0) begin
            errors++;
            $display("FAIL reset_status1 got %b expected %b", status1(), 7'b0);
        end
        checks++;
        if (status3() !== 7'b0) begin
            errors++;
            $display("FAIL reset_status3 got %b expected %b", status3(), 7'b0);
        end
        checks++;
        ln = lane_diff1();
        if (ln >= 0) begin
            errors++;
            $display("FAIL reset_lanes lane %0d got %0d expected 0", ln, if1.mul_din_R[ln]);
        end
        rst = 1'b0;
        drive1(1'b0, 1'b0, 9);
        drive3(1'b0, 1'b0, 9);
        tick();
    endtask

    task automatic test_basic_frame();
        row_t rows [11];
        logic [6:0] exp;
        int ln;
        rows = '{
            '{0,1,1,0, 1,0,0,0,0}, '{0,0,1,1, 1,1,1,0,0}, '{0,0,1,2, 1,2,1,0,0},
            '{0,0,1,3, 1,3,1,0,0}, '{0,0,1,4, 1,4,1,0,0}, '{0,0,1,5, 1,5,1,0,0},
            '{0,0,1,6, 1,6,1,0,0}, '{0,0,1,7, 1,7,1,0,0}, '{0,0,0,9, 0,7,1,1,0},
            '{0,0,0,9, 0,7,0,0,0}, '{0,0,0,9, 0,7,0,0,0}
        };
        foreach (rows[r]) begin
            rst = rows[r].rst;
            drive1(rows[r].fs, rows[r].v, rows[r].tag);
            tick();
            if (rows[r].rst || rows[r].mv) set_exp1(rows[r].rst, rows[r].tag);
            exp = {rows[r].mv, 3'(rows[r].sel), rows[r].dv, rows[r].dl, rows[r].fe};
            checks++;
            if (status1() !== exp) begin
                errors++;
                $display("FAIL basic_status row %0d got %b expected %b", r, status1(), exp);
            end
            checks++;
            ln = lane_diff1();
            if (ln >= 0) begin
                errors++;
                $display("FAIL basic_lanes row %0d lane %0d got %0d expected %0d",
                         r, ln, if1.mul_din_R[ln], exp_r[ln]);
            end
        end
    endtask

    task automatic test_gap();
        row_t rows [14];
        logic [6:0] exp;
        int ln;
        int dv_cnt = 0;
        rows = '{
            '{0,1,1,0, 1,0,0,0,0}, '{0,0,1,1, 1,1,1,0,0}, '{0,0,1,2, 1,2,1,0,0},
            '{0,0,1,3, 1,3,1,0,0}, '{0,0,0,9, 0,3,1,0,0}, '{0,0,0,9, 0,3,0,0,0},
            '{0,0,0,9, 0,3,0,0,0}, '{0,0,1,4, 1,4,0,0,0}, '{0,0,1,5, 1,5,1,0,0},
            '{0,0,1,6, 1,6,1,0,0}, '{0,0,1,7, 1,7,1,0,0}, '{0,0,0,9, 0,7,1,1,0},
            '{0,0,0,9, 0,7,0,0,0}, '{0,0,0,9, 0,7,0,0,0}
        };
        foreach (rows[r]) begin
            rst = rows[r].rst;
            drive1(rows[r].fs, rows[r].v, rows[r].tag);
            tick();
            if (rows[r].rst || rows[r].mv) set_exp1(rows[r].rst, rows[r].tag);
            if (if1.dout_valid === 1'b1) dv_cnt++;
            exp = {rows[r].mv, 3'(rows[r].sel), rows[r].dv, rows[r].dl, rows[r].fe};
            checks++;
            if (status1() !== exp) begin
                errors++;
                $display("FAIL gap_status row %0d got %b expected %b", r, status1(), exp);
            end
            checks++;
            ln = lane_diff1();
            if (ln >= 0) begin
                errors++;
                $display("FAIL gap_lanes row %0d lane %0d got %0d expected %0d",
                         r, ln, if1.mul_din_R[ln], exp_r[ln]);
            end
        end
        checks++;
        if (dv_cnt != 8) begin
            errors++;
            $display("FAIL gap_dout_count got %0d expected 8", dv_cnt);
        end
    endtask

    task automatic test_idle_error();
        row_t rows [3];
        logic [6:0] exp;
        int ln;
        rows = '{
            '{0,0,1,5, 0,7,0,0,1}, '{0,0,1,2, 0,7,0,0,1}, '{0,0,0,9, 0,7,0,0,0}
        };
        foreach (rows[r]) begin
            rst = rows[r].rst;
            drive1(rows[r].fs, rows[r].v, rows[r].tag);
            tick();
            if (rows[r].rst || rows[r].mv) set_exp1(rows[r].rst, rows[r].tag);
            exp = {rows[r].mv, 3'(rows[r].sel), rows[r].dv, rows[r].dl, rows[r].fe};
            checks++;
            if (status1() !== exp) begin
                errors++;
                $display("FAIL idle_err_status row %0d got %b expected %b", r, status1(), exp);
            end
            checks++;
            ln = lane_diff1();
            if (ln >= 0) begin
                errors++;
                $display("FAIL idle_err_lanes row %0d lane %0d got %0d expected %0d",
                         r, ln, if1.mul_din_R[ln], exp_r[ln]);
            end
        end
    endtask

    task automatic test_restart();
        row_t rows [16];
        logic [6:0] exp;
        int ln;
        rows = '{
            '{0,1,1,0,  1,0,0,0,0}, '{0,0,1,1,  1,1,1,0,0}, '{0,0,1,2,  1,2,1,0,0},
            '{0,0,1,3,  1,3,1,0,0}, '{0,0,1,4,  1,4,1,0,0}, '{0,1,1,10, 1,0,1,0,1},
            '{0,0,1,11, 1,1,1,0,0}, '{0,0,1,12, 1,2,1,0,0}, '{0,0,1,13, 1,3,1,0,0},
            '{0,0,1,14, 1,4,1,0,0}, '{0,0,1,15, 1,5,1,0,0}, '{0,0,1,16, 1,6,1,0,0},
            '{0,0,1,17, 1,7,1,0,0}, '{0,0,0,9,  0,7,1,1,0}, '{0,0,0,9,  0,7,0,0,0},
            '{0,0,0,9,  0,7,0,0,0}
        };
        foreach (rows[r]) begin
            rst = rows[r].rst;
            drive1(rows[r].fs, rows[r].v, rows[r].tag);
            tick();
            if (rows[r].rst || rows[r].mv) set_exp1(rows[r].rst, rows[r].tag);
            exp = {rows[r].mv, 3'(rows[r].sel), rows[r].dv, rows[r].dl, rows[r].fe};
            checks++;
            if (status1() !== exp) begin
                errors++;
                $display("FAIL restart_status row %0d got %b expected %b", r, status1(), exp);
            end
            checks++;
            ln = lane_diff1();
            if (ln >= 0) begin
                errors++;
                $display("FAIL restart_lanes row %0d lane %0d got %0d expected %0d",
                         r, ln, if1.mul_din_R[ln], exp_r[ln]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        int ln;
        int mv_run = 0;
        int mv_best = 0;
        int dv_cnt = 0;
        for (int r = 0; r < 20; r++) begin
            drive3(r < 16 && r % 8 == 0, r < 16, r < 16 ? r : 9);
            tick();
            if (r < 16) set_exp3(1'b0, r);
            exp = {(r < 16) ? 1'b1 : 1'b0,
                   (r < 16) ? 3'(r % 8) : 3'd7,
                   (r >= 3 && r <= 18) ? 1'b1 : 1'b0,
                   (r == 10 || r == 18) ? 1'b1 : 1'b0,
                   1'b0};
            if (if3.mul_valid === 1'b1) begin
                mv_run++;
                if (mv_run > mv_best) mv_best = mv_run;
            end else begin
                mv_run = 0;
            end
            if (if3.dout_valid === 1'b1) dv_cnt++;
            checks++;
            if (status3() !== exp) begin
                errors++;
                $display("FAIL b2b_status row %0d got %b expected %b", r, status3(), exp);
            end
            checks++;
            ln = lane_diff3();
            if (ln >= 0) begin
                errors++;
                $display("FAIL b2b_lanes row %0d lane %0d got %0d expected %0d",
                         r, ln, if3.mul_din_R[ln], exp3_r[ln]);
            end
        end
        checks++;
        if (mv_best != 16) begin
            errors++;
            $display("FAIL b2b_mul_run got %0d expected 16", mv_best);
        end
        checks++;
        if (dv_cnt != 16) begin
            errors++;
            $display("FAIL b2b_dout_count got %0d expected 16", dv_cnt);
        end
    endtask

    task automatic test_reset_mid();
        row_t rows [13];
        logic [6:0] exp;
        int ln;
        rows = '{
            '{0,1,1,0, 1,0,0,0,0}, '{0,0,1,1, 1,1,1,0,0}, '{0,0,1,2, 1,2,1,0,0},
            '{0,0,1,3, 1,3,1,0,0}, '{1,0,1,4, 0,0,0,0,0}, '{0,0,0,9, 0,0,0,0,0},
            '{0,0,0,9, 0,0,0,0,0}, '{0,0,0,9, 0,0,0,0,0}, '{0,0,0,9, 0,0,0,0,0},
            '{0,0,1,5, 0,0,0,0,1}, '{0,0,0,9, 0,0,0,0,0}, '{0,1,1,6, 1,0,0,0,0},
            '{0,0,0,9, 0,0,1,0,0}
        };
        foreach (rows[r]) begin
            rst = rows[r].rst;
            drive1(rows[r].fs, rows[r].v, rows[r].tag);
            tick();
            if (rows[r].rst || rows[r].mv) set_exp1(rows[r].rst, rows[r].tag);
            exp = {rows[r].mv, 3'(rows[r].sel), rows[r].dv, rows[r].dl, rows[r].fe};
            checks++;
            if (status1() !== exp) begin
                errors++;
                $display("FAIL reset_mid_status row %0d got %b expected %b", r, status1(), exp);
            end
            checks++;
            ln = lane_diff1();
            if (ln >= 0) begin
                errors++;
                $display("FAIL reset_mid_lanes row %0d lane %0d got %0d expected %0d",
                         r, ln, if1.mul_din_R[ln], exp_r[ln]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_frame();
        test_gap();
        test_idle_error();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
